// File: rtl/harvard_data_mem_if.sv
// rtl/harvard_data_mem_if.sv - CPU data-port bus between the Harvard core and its data memory
interface harvard_data_mem_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output data_address,
        output data_read,
        output data_write,
        output data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address,
        input  data_read,
        input  data_write,
        input  data_writedata,
        output data_readdata
    );
endinterface

// File: rtl/harvard_data_mem.sv
// rtl/harvard_data_mem.sv - data-side memory with zero-fill sweep, sticky access fault and write counter
module harvard_data_mem #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                reset,
    harvard_data_mem_if.slave   bus,
    output logic                ready,
    input  logic                fault_clear,
    output logic                fault,
    output logic [31:0]         fault_addr,
    output logic [15:0]         write_count
);
    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [32:0] WINDOW   = 33'd4 << ADDR_WIDTH;
    localparam logic [0:0]  ST_INIT  = 1'b0;
    localparam logic [0:0]  ST_SERVE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_idx_q, clear_idx_d;
    logic                  fault_q, fault_d;
    logic [31:0]           fault_addr_q, fault_addr_d;
    logic [15:0]           write_count_q, write_count_d;
    logic [31:0]           mem_q [DEPTH];

    logic                  serve;
    logic [31:0]           offset;
    logic                  in_range;
    logic                  aligned;
    logic                  valid;
    logic                  wr_en;
    logic                  fault_cond;
    logic [ADDR_WIDTH-1:0] index;

    // Underflow below BASE_ADDR wraps to a huge offset and so falls out of the window.
    assign serve      = (state_q == ST_SERVE);
    assign offset     = bus.data_address - BASE_ADDR;
    assign in_range   = ({1'b0, offset} < WINDOW);
    assign aligned    = (bus.data_address[1:0] == 2'b00);
    assign valid      = in_range && aligned;
    assign index      = offset[ADDR_WIDTH+1:2];
    assign wr_en      = serve && !reset && bus.data_write && valid;
    assign fault_cond = serve && (bus.data_read || bus.data_write) && !valid;

    assign bus.data_readdata = (serve && bus.data_read && valid) ? mem_q[index] : 32'h0;
    assign ready       = serve;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign write_count = write_count_q;

    always_comb begin
        state_d       = state_q;
        clear_idx_d   = clear_idx_q;
        fault_d       = fault_q;
        fault_addr_d  = fault_addr_q;
        write_count_d = write_count_q;

        if (state_q == ST_INIT) begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (&clear_idx_q) begin
                state_d = ST_SERVE;
            end
        end

        if (wr_en && (write_count_q != 16'hFFFF)) begin
            write_count_d = write_count_q + 16'd1;
        end

        // A clear coinciding with a new fault re-arms capture on the new address.
        if (fault_cond) begin
            fault_d = 1'b1;
            if (!fault_q || fault_clear) begin
                fault_addr_d = bus.data_address;
            end
        end else if (fault_clear) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            clear_idx_q   <= '0;
            fault_q       <= 1'b0;
            fault_addr_q  <= 32'h0;
            write_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            clear_idx_q   <= clear_idx_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
            write_count_q <= write_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[clear_idx_q] <= 32'h0;
        end else if (wr_en) begin
            mem_q[index] <= bus.data_writedata;
        end
    end
endmodule

// File: tb/tb_harvard_data_mem.sv
// tb/tb_harvard_data_mem.sv - randomized self-checking bench for harvard_data_mem
module tb_harvard_data_mem;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fault_clear;
    logic        ready;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] write_count;

    harvard_data_mem_if bus_if ();

    harvard_data_mem #(.ADDR_WIDTH(10), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .ready       (ready),
        .fault_clear (fault_clear),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    int          m_init;
    bit          m_fault;
    logic [31:0] m_faddr;
    int          m_wc;
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off < 32'(4 * DEPTH)) && (addr % 4 == 0);
    endfunction

    // One clock: drive inputs, check the combinational read, advance model, check registers.
    task automatic step(input bit rst, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit fclr);
        logic [31:0] exp_rd;
        bit          ok;
        int          idx;
        reset                 = rst;
        fault_clear           = fclr;
        bus_if.data_address   = addr;
        bus_if.data_read      = rd;
        bus_if.data_write     = wr;
        bus_if.data_writedata = wd;
        ok  = addr_ok(addr);
        idx = int'((addr - BASE) / 4);
        exp_rd = 32'h0;
        if (m_ready && rd && ok) exp_rd = m_mem[idx];
        #1;
        last_rd = bus_if.data_readdata;
        check("readdata", last_rd, exp_rd);
        @(posedge clk);
        if (rst) begin
            m_ready = 0; m_init = 0; m_fault = 0; m_faddr = 32'h0; m_wc = 0;
        end else if (!m_ready) begin
            m_init++;
            if (m_init == DEPTH) begin
                m_ready = 1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end
        end else begin
            if (wr && ok) begin
                m_mem[idx] = wd;
                if (m_wc < 65535) m_wc++;
            end
            if ((rd || wr) && !ok) begin
                if (!m_fault || fclr) m_faddr = addr;
                m_fault = 1;
            end else if (fclr) begin
                m_fault = 0;
            end
        end
        #1;
        check("ready", 32'(ready), 32'(m_ready));
        check("fault", 32'(fault), 32'(m_fault));
        check("fault_addr", fault_addr, m_faddr);
        check("write_count", 32'(write_count), 32'(m_wc));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom % 5)
            0, 1:    a = BASE + 4 * ($urandom % DEPTH);
            2:       a = BASE + 4 * ($urandom % DEPTH) + 1 + ($urandom % 3);
            3: begin
                case ($urandom % 4)
                    0:       a = 32'h0000_0FFC;
                    1:       a = 32'h0000_2000;
                    2:       a = 32'h0000_1FFC;
                    default: a = 32'h0000_1000;
                endcase
            end
            default: a = $urandom;
        endcase
        return a;
    endfunction

    int edges;

    initial begin
        bus_if.data_address = 32'h0; bus_if.data_read = 1'b0; bus_if.data_write = 1'b0;
        bus_if.data_writedata = 32'h0; fault_clear = 1'b0; reset = 1'b1;
        m_ready = 0; m_init = 0; m_fault = 0; m_faddr = 32'h0; m_wc = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        check("rst_write_count", 32'(write_count), 32'h0);

        // Partial sweep, then reset must restart it from the beginning.
        for (int i = 0; i < 100; i++) step(0, 1, 0, 32'h1000, 32'h0, 0);
        step(1, 0, 0, 32'h0, 32'h0, 0);
        edges = 0;
        while (!ready && edges < 1100) begin
            step(0, 1, 1, 32'h1000, 32'h1234_5678, 0);
            edges++;
        end
        check("sweep_edges", 32'(edges), 32'd1024);

        step(0, 0, 1, 32'h1004, 32'hDEADBEEF, 0);
        step(0, 1, 0, 32'h1004, 32'h0, 0);
        check("rd_1004", last_rd, 32'hDEADBEEF);
        step(0, 1, 0, 32'h1000, 32'h0, 0);
        check("rd_1000", last_rd, 32'h0);
        check("wc_one", 32'(write_count), 32'd1);

        step(0, 1, 0, 32'h1002, 32'h0, 0);
        check("rd_misaligned", last_rd, 32'h0);
        check("fault_set", 32'(fault), 32'd1);
        check("faddr_first", fault_addr, 32'h1002);
        step(0, 1, 0, 32'h0FFC, 32'h0, 0);
        check("faddr_held", fault_addr, 32'h1002);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("fault_cleared", 32'(fault), 32'd0);
        check("faddr_kept", fault_addr, 32'h1002);

        step(0, 0, 1, 32'h1FFC, 32'h5A5A5A5A, 0);
        step(0, 1, 0, 32'h1FFC, 32'h0, 0);
        check("rd_last_word", last_rd, 32'h5A5A5A5A);
        step(0, 0, 1, 32'h2000, 32'h1111_1111, 0);
        check("fault_2000", fault_addr, 32'h2000);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 32'h0, 0);
        check("fault_underflow", 32'(fault), 32'd1);
        check("faddr_underflow", fault_addr, 32'h0);

        step(0, 0, 1, 32'h1010, 32'd7, 0);
        step(0, 1, 1, 32'h1010, 32'd9, 0);
        check("rmw_old", last_rd, 32'd7);
        step(0, 1, 0, 32'h1010, 32'h0, 0);
        check("rmw_new", last_rd, 32'd9);

        step(0, 1, 0, 32'h1003, 32'h0, 1);
        check("clr_with_fault", fault_addr, 32'h1003);
        check("clr_with_fault_flag", 32'(fault), 32'd1);

        for (int i = 0; i < 400; i++)
            step(0, 1'($urandom), 1'($urandom), rand_addr(), $urandom, ($urandom % 8) == 0);

        for (int i = 0; i < 65540; i++)
            step(0, 0, 1, BASE + 4 * ($urandom % DEPTH), $urandom, 0);
        check("wc_saturated", 32'(write_count), 32'h0000_FFFF);

        step(0, 0, 1, 32'h1004, 32'hCAFE_F00D, 0);
        step(0, 1, 0, 32'h1001, 32'h0, 0);
        step(1, 0, 0, 32'h0, 32'h0, 0);
        check("serve_rst_ready", 32'(ready), 32'd0);
        check("serve_rst_wc", 32'(write_count), 32'd0);
        check("serve_rst_fault", 32'(fault), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h1004, 32'h0, 0);
        step(0, 1, 0, 32'h1004, 32'h0, 0);
        check("rd_1004_after_sweep", last_rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/harvard_data_mem.md
# harvard_data_mem

Data-side memory responder for the Harvard CPU's data port. It answers combinational reads and commits single-cycle writes on the same `data_address` / `data_read` / `data_write` / `data_writedata` / `data_readdata` signal set the CPU drives. After reset it zero-fills the whole array with a sweep FSM before it will serve accesses. It also flags misaligned and out-of-window accesses with a sticky fault and the address of the first offending access.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; DEPTH = 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h0000_1000: byte address of word 0; must be 4-byte aligned.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `data_address`  in  32  byte address from the CPU.
- `data_read`  in  1  read strobe.
- `data_write`  in  1  write strobe.
- `data_writedata`  in  32  store data.
- `data_readdata`  out  32  combinational read data.
- `ready`  out  1  high once the init sweep is complete.
- `fault_clear`  in  1  clears the sticky fault.
- `fault`  out  1  sticky access-fault flag.
- `fault_addr`  out  32  `data_address` of the first fault since the last clear.
- `write_count`  out  16  saturating count of committed writes.

## Operation
- State machine has two states, INIT and SERVE.
- `reset` high forces the following at the clock edge, from any state and including mid-sweep: state = INIT, clear_idx = 0, `ready` = 0, `fault` = 0, `fault_addr` = 0, `write_count` = 0.
- **INIT:**
  - Each edge writes 0 to mem[clear_idx] and increments clear_idx.
  - The edge that writes mem[DEPTH-1] moves the state to SERVE.
  - CPU accesses are ignored: no write, `data_readdata` = 0, no fault, no count.
- **SERVE:**
  - `ready` = 1.
  - Decode: offset = `data_address` - `BASE_ADDR`, unsigned 32-bit. The access is in range iff offset < 4*DEPTH; underflow wraps to a large value and therefore reads as out of range. It is aligned iff `data_address[1:0]` == 0. Word index = offset[ADDR_WIDTH+1:2].
  - A valid access is one that is in range and aligned.
  - Read: `data_readdata` = mem[index] when `data_read` is high and the access is valid; otherwise 0. The read is purely combinational, with no registered output.
  - Write: mem[index] <= `data_writedata` at the edge when `data_write` is high and the access is valid. `write_count` increments, saturating at 16'hFFFF.
  - `data_read` and `data_write` both high on a valid access: the write commits at the edge, and `data_readdata` shows the pre-write value during that cycle.
  - Fault condition: (`data_read` | `data_write`) and not valid. The access is suppressed (no write, readdata 0) and `fault` is set at the edge. `fault_addr` is loaded only if `fault` was 0 before that edge, so it holds the first fault.
  - `fault_clear` alone clears `fault` at the edge; `fault_addr` keeps its value.
  - `fault_clear` together with a new fault condition: `fault` stays 1 and `fault_addr` loads the new address.
- Strobes low means no side effects and `data_readdata` = 0.

## Timing
- Read latency is 0 cycles (combinational from address and strobe).
- Write takes effect at the strobe edge and is visible to a read in the next cycle.
- Init sweep:
  - Takes exactly DEPTH edges with `reset` low.
  - `ready` rises DEPTH edges after the first edge at which `reset` is sampled low.
  - Default DEPTH is 1024 edges.
- `fault`, `fault_addr` and `write_count` are registered and change one edge after the triggering access.
- Reset asserted mid-sweep restarts the sweep at clear_idx 0. Memory contents not yet re-zeroed are irrelevant because reads return 0 until `ready` is high.

## Test plan
- Reset for 2 cycles, then release → `ready` = 0 for 1024 edges and 1 from the following cycle; a read of 32'h1000 during INIT returns 0 and `fault` stays 0.
- After `ready`, write 32'hDEADBEEF to 32'h1004, then read 32'h1004 on the next cycle → 32'hDEADBEEF; a read of 32'h1000 → 0; `write_count` = 1.
- Read of 32'h1002 → `data_readdata` 0 and `fault` = 1 next cycle with `fault_addr` = 32'h1002. A second bad read at 32'h0FFC → `fault_addr` stays 32'h1002. Pulsing `fault_clear` → `fault` = 0.
- Boundary: write 32'h5A5A5A5A to 32'h1FFC (last word) → stored and read back. Write to 32'h2000 → no store and `fault` = 1. A read of 32'h0000_0000 (underflow) → fault.
- `data_read` and `data_write` both high on 32'h1010 (old value 7, new value 9) → readdata shows 7 that cycle and 9 the next.
- Assert `reset` mid-SERVE after writes → `ready` = 0, `write_count` = 0, `fault` = 0; after the 1024-edge sweep, a read of the previously written 32'h1004 returns 0.
